// File: rtl/spi_pkg.sv
// Shared state type, SPI mode encodings and sck edge selection for spi_reg_slave.
package spi_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA} spi_state_t;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Sample edge is the rising sck edge when the leading edge is rising and
  // CPHA=0, or the leading edge is falling and CPHA=1.
  function automatic logic sampleOnRise(input logic cpol, input logic cpha);
    return cpol == cpha;
  endfunction

endpackage

// File: rtl/spi_reg_slave_sync_edge.sv
// Two-flop synchroniser with registered previous value for edge detection.
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      prev <= RESET_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_slave.sv
// Oversampled SPI slave running auto-incrementing burst reads/writes on a register bus.
// Optional frame_err/err_count outputs are enabled with `define SPI_FRAME_ERR_EN.
module spi_reg_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 7,
  parameter int CPOL       = 0,
  parameter int CPHA       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                  frame_err,
  output logic [7:0]            err_count
`endif
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  localparam logic SAMPLE_RISE = sampleOnRise(CPOL[0], CPHA[0]);

  logic csSync, csRise, csFall;
  logic unusedSckSync, sckRise, sckFall;
  logic mosiMeta, mosiSync;
  logic sampleEdge, shiftEdge;
  logic armed, isWrite, rdEnDly, incPending;
  logic startFrame, cmdDone, dataDone, abort;
  logic [CNT_W-1:0] bitCnt;
  logic [DATA_WIDTH-2:0] rxShift;
  logic [DATA_WIDTH-1:0] rxWord, txShift;
  spi_state_t state, stateNext;

  // cs syncs from 0 so a frame already running at reset release never arms
  spi_sync_edge #(.RESET_VAL(1'b0)) csSyncEdge (
    .clk(clk), .reset(reset), .din(cs), .sync(csSync), .rise(csRise), .fall(csFall)
  );

  spi_sync_edge #(.RESET_VAL(CPOL[0])) sckSyncEdge (
    .clk(clk), .reset(reset), .din(sck), .sync(unusedSckSync), .rise(sckRise), .fall(sckFall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mosiMeta <= 1'b0;
      mosiSync <= 1'b0;
    end else begin
      mosiMeta <= mosi;
      mosiSync <= mosiMeta;
    end
  end

  assign sampleEdge = SAMPLE_RISE ? sckRise : sckFall;
  assign shiftEdge  = SAMPLE_RISE ? sckFall : sckRise;
  assign rxWord     = {rxShift, mosiSync};
  assign abort      = csRise && (state != IDLE);

  // state | meaning
  // IDLE  | deselected or unarmed, waiting for cs to fall
  // CMD   | receiving the R/W + start address word
  // DATA  | burst data words, address auto-increments
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    startFrame = 1'b0;
    cmdDone    = 1'b0;
    dataDone   = 1'b0;
    if (csSync) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: if (csFall && armed) begin
          stateNext  = CMD;
          startFrame = 1'b1;
        end
        CMD: if (sampleEdge && bitCnt == LAST_BIT) begin
          stateNext = DATA;
          cmdDone   = 1'b1;
        end
        DATA: dataDone = sampleEdge && bitCnt == LAST_BIT;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed      <= 1'b0;
      isWrite    <= 1'b0;
      rdEnDly    <= 1'b0;
      incPending <= 1'b0;
      bitCnt     <= '0;
      rxShift    <= '0;
      txShift    <= '0;
      reg_addr   <= '0;
      wr_en      <= 1'b0;
      wr_data    <= '0;
      rd_en      <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      rdEnDly <= rd_en;
      if (csSync) armed <= 1'b1;

      if (startFrame || abort)
        bitCnt <= '0;
      else if (sampleEdge && state != IDLE)
        bitCnt <= (bitCnt == LAST_BIT) ? '0 : bitCnt + CNT_W'(1);

      if (sampleEdge && state != IDLE) rxShift <= rxWord[DATA_WIDTH-2:0];

      if (incPending) begin
        reg_addr   <= reg_addr + ADDR_WIDTH'(1);
        incPending <= 1'b0;
      end

      if (cmdDone) begin
        isWrite  <= rxWord[DATA_WIDTH-1];
        reg_addr <= rxWord[ADDR_WIDTH-1:0];
        rd_en    <= ~rxWord[DATA_WIDTH-1];
      end else if (dataDone) begin
        if (isWrite) begin
          wr_en      <= 1'b1;
          wr_data    <= rxWord;
          incPending <= 1'b1;
        end else begin
          reg_addr <= reg_addr + ADDR_WIDTH'(1);
          rd_en    <= 1'b1;
        end
      end

      // Shift edges right after a word boundary are skipped so the freshly
      // loaded MSB stays on miso for the first bit of the next word.
      if (startFrame || abort)
        txShift <= '0;
      else if (rdEnDly && state == DATA)
        txShift <= rd_data;
      else if (shiftEdge && state != IDLE && bitCnt != '0)
        txShift <= {txShift[DATA_WIDTH-2:0], 1'b0};
    end
  end

  assign miso    = txShift[DATA_WIDTH-1];
  assign miso_oe = armed & ~csSync;
  assign busy    = (state != IDLE);

`ifdef SPI_FRAME_ERR_EN
  logic frameAbort;
  assign frameAbort = abort && (state == CMD || bitCnt != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= frameAbort;
      if (frameAbort && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench: a mode-0 8/7 instance and a mode-3 16/10 instance against a register model.
module tb_spi_reg_slave;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] csM = 2'b11;
  logic [1:0] sckM = 2'b10;
  logic [1:0] mosiM = 2'b00;

  int dw[2] = '{8, 16};
  int aw[2] = '{7, 10};
  logic cpolT[2] = '{1'b0, 1'b1};
  logic cphaT[2] = '{1'b0, 1'b1};

  logic misoA, oeA, wrA, rdA, busyA;
  logic [6:0] addrA;
  logic [7:0] wdA, rdDataA = '0;
  logic misoB, oeB, wrB, rdB, busyB;
  logic [9:0] addrB;
  logic [15:0] wdB, rdDataB = '0;
`ifdef SPI_FRAME_ERR_EN
  logic ferrA, ferrB;
  logic [7:0] ecntA, ecntB;
  int errSeen = 0, expErr = 0;
`endif

  always #5 clk = ~clk;

  spi_reg_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .CPOL(0), .CPHA(0)) dutA (
    .clk(clk), .reset(reset), .cs(csM[0]), .sck(sckM[0]), .mosi(mosiM[0]),
    .miso(misoA), .miso_oe(oeA), .reg_addr(addrA), .wr_en(wrA), .wr_data(wdA),
    .rd_en(rdA), .rd_data(rdDataA), .busy(busyA)
`ifdef SPI_FRAME_ERR_EN
    , .frame_err(ferrA), .err_count(ecntA)
`endif
  );

  spi_reg_slave #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .CPOL(1), .CPHA(1)) dutB (
    .clk(clk), .reset(reset), .cs(csM[1]), .sck(sckM[1]), .mosi(mosiM[1]),
    .miso(misoB), .miso_oe(oeB), .reg_addr(addrB), .wr_en(wrB), .wr_data(wdB),
    .rd_en(rdB), .rd_data(rdDataB), .busy(busyB)
`ifdef SPI_FRAME_ERR_EN
    , .frame_err(ferrB), .err_count(ecntB)
`endif
  );

  // External register files: single-cycle write, read data valid the clk after rd_en.
  logic [7:0]  regsA [128];
  logic [15:0] regsB [1024];
  initial begin
    for (int i = 0; i < 128; i++) regsA[i] = 8'(i ^ 'h3C);
    for (int i = 0; i < 1024; i++) regsB[i] = 16'(i ^ 'h3C);
    forever begin
      @(posedge clk);
      if (wrA) regsA[addrA] <= wdA;
      if (rdA) rdDataA <= regsA[addrA];
      if (wrB) regsB[addrB] <= wdB;
      if (rdB) rdDataB <= regsB[addrB];
    end
  end

  int nVec = 0, nErr = 0;
  logic [63:0] expWr[$], expRd[$], expMiso[$], rxQ[$];
  logic [15:0] modelMem [2][1024];
  logic [15:0] dataIn [4];

  function automatic logic [63:0] key(input int inst, input logic [15:0] a, input logic [15:0] d);
    return (64'(inst) << 32) | (64'(a) << 16) | 64'(d);
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic void unexpected(input string name);
    nVec++;
    nErr++;
    $display("FAIL %s: output seen with nothing expected", name);
  endfunction

  // Monitor: pops expectations whenever the DUTs present a strobe or a received word.
  always @(negedge clk) begin
    if (!reset) begin
      if (wrA) begin
        if (expWr.size() == 0) unexpected("wr_en A");
        else check("wr A", key(0, 16'(addrA), 16'(wdA)), expWr.pop_front());
      end
      if (wrB) begin
        if (expWr.size() == 0) unexpected("wr_en B");
        else check("wr B", key(1, 16'(addrB), wdB), expWr.pop_front());
      end
      if (rdA) begin
        if (expRd.size() == 0) unexpected("rd_en A");
        else check("rd A", key(0, 16'(addrA), 16'h0), expRd.pop_front());
      end
      if (rdB) begin
        if (expRd.size() == 0) unexpected("rd_en B");
        else check("rd B", key(1, 16'(addrB), 16'h0), expRd.pop_front());
      end
      if (rxQ.size() > 0) begin
        if (expMiso.size() == 0) begin
          void'(rxQ.pop_front());
          unexpected("miso word");
        end else check("miso word", rxQ.pop_front(), expMiso.pop_front());
      end
`ifdef SPI_FRAME_ERR_EN
      if (ferrA) errSeen++;
      if (ferrB) errSeen++;
`endif
    end
  end

  task automatic halfWait();
    repeat (HALF) @(negedge clk);
  endtask

  function automatic logic misoOf(input int inst);
    return (inst == 0) ? misoA : misoB;
  endfunction

  task automatic sendBits(input int inst, input logic [15:0] val, input int nBits, output logic [15:0] got);
    int w;
    logic b;
    w = dw[inst];
    got = '0;
    for (int i = 0; i < nBits; i++) begin
      b = val[w-1-i];
      if (!cphaT[inst]) begin
        mosiM[inst] = b;
        halfWait();
        sckM[inst] = ~cpolT[inst];
        got = {got[14:0], misoOf(inst)};
        halfWait();
        sckM[inst] = cpolT[inst];
      end else begin
        sckM[inst] = ~cpolT[inst];
        mosiM[inst] = b;
        halfWait();
        sckM[inst] = cpolT[inst];
        got = {got[14:0], misoOf(inst)};
        halfWait();
      end
    end
  endtask

  task automatic frameStart(input int inst);
    csM[inst] = 1'b0;
    halfWait();
    check("miso_oe selected", (inst == 0) ? oeA : oeB, 1'b1);
  endtask

  task automatic frameEnd(input int inst);
    halfWait();
    csM[inst] = 1'b1;
    repeat (3) @(negedge clk);
    check("busy after cs high", (inst == 0) ? busyA : busyB, 1'b0);
    repeat (6) @(negedge clk);
    check("wr queue drained", 64'(expWr.size()), 64'd0);
    check("rd queue drained", 64'(expRd.size()), 64'd0);
    check("miso queue drained", 64'(expMiso.size()), 64'd0);
  endtask

  // Reference behaviour: a write burst lands word k at (addr+k) mod 2^AW; a read burst
  // strobes addr..addr+n and returns mem[addr+k]; a partial trailing word does nothing.
  task automatic runFrame(input int inst, input bit isWr, input int addr, input int nWords, input int abortBits);
    int w, amask, a;
    logic [15:0] cmd, got;
    w = dw[inst];
    amask = (1 << aw[inst]) - 1;
    cmd = 16'(addr & amask);
    if (isWr) cmd = cmd | 16'(1 << (w - 1));
    if (!isWr) expRd.push_back(key(inst, 16'(addr & amask), 16'h0));
    for (int k = 0; k < nWords; k++) begin
      a = (addr + k) & amask;
      if (isWr) begin
        expWr.push_back(key(inst, 16'(a), dataIn[k]));
        modelMem[inst][a] = dataIn[k];
      end else begin
        expMiso.push_back(key(inst, 16'h0, modelMem[inst][a]));
        expRd.push_back(key(inst, 16'((addr + k + 1) & amask), 16'h0));
      end
    end
`ifdef SPI_FRAME_ERR_EN
    if (abortBits > 0) expErr++;
`endif
    frameStart(inst);
    sendBits(inst, cmd, w, got);
    check("miso during cmd", 64'(got), 64'd0);
    for (int k = 0; k < nWords; k++) begin
      sendBits(inst, isWr ? dataIn[k] : 16'($urandom), w, got);
      if (!isWr) rxQ.push_back(key(inst, 16'h0, got));
    end
    if (abortBits > 0) sendBits(inst, 16'($urandom), abortBits, got);
    frameEnd(inst);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] junk;
    int inst, n, ab;
    for (int i = 0; i < 1024; i++) begin
      modelMem[0][i] = 16'(i ^ 'h3C);
      modelMem[1][i] = 16'(i ^ 'h3C);
    end
    repeat (3) @(negedge clk);
    check("reset miso_oe A", oeA, 1'b0);
    check("reset busy A", busyA, 1'b0);
    check("reset reg_addr A", 64'(addrA), 64'd0);
    check("reset strobes/miso A", {wrA, rdA, misoA}, 3'b000);
    check("reset wr_data A", 64'(wdA), 64'd0);
    check("reset outputs B", {oeB, busyB, wrB, rdB, misoB, addrB, wdB}, 31'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("miso_oe deselected", oeA, 1'b0);

    dataIn[0] = 16'hAA; dataIn[1] = 16'h55;
    runFrame(0, 1'b1, 'h05, 2, 0);
    runFrame(0, 1'b0, 'h10, 3, 0);
    dataIn[0] = 16'h3E; dataIn[1] = 16'hC1;
    runFrame(0, 1'b1, 'h7F, 2, 0);
    dataIn[0] = 16'h99; dataIn[1] = 16'h66;
    runFrame(0, 1'b1, 'h20, 1, 5);
    runFrame(0, 1'b0, 'h7F, 2, 0);

    // Reset in the middle of a command word, released while cs is still low.
    csM[0] = 1'b0;
    halfWait();
    sendBits(0, 16'h81, 4, junk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("miso_oe after mid-frame reset", oeA, 1'b0);
    check("busy after mid-frame reset", busyA, 1'b0);
    sendBits(0, 16'h18, 4, junk);
    sendBits(0, 16'h5A, 8, junk);
    check("miso_oe stays off until cs high", oeA, 1'b0);
    frameEnd(0);
    dataIn[0] = 16'h12; dataIn[1] = 16'h34;
    runFrame(0, 1'b1, 'h40, 2, 0);
    runFrame(0, 1'b0, 'h40, 2, 0);

    runFrame(1, 1'b0, 'h3FF, 2, 0);
    dataIn[0] = 16'hBEEF; dataIn[1] = 16'h8001; dataIn[2] = 16'h7FFE;
    runFrame(1, 1'b1, 'h3FE, 3, 0);
    runFrame(1, 1'b0, 'h3FE, 3, 0);

    for (int f = 0; f < 16; f++) begin
      inst = ($urandom_range(0, 3) == 0) ? 1 : 0;
      n = $urandom_range(1, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dw[inst] - 1) : 0;
      for (int k = 0; k < 4; k++) dataIn[k] = 16'($urandom) & 16'((1 << dw[inst]) - 1);
      runFrame(inst, 1'($urandom_range(0, 1)), int'($urandom_range(0, (1 << aw[inst]) - 1)), n, ab);
    end

`ifdef SPI_FRAME_ERR_EN
    check("frame_err pulses", 64'(errSeen), 64'(expErr));
    check("err_count total", 64'(ecntA) + 64'(ecntB), 64'(expErr));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
